// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 decoder: tracks E0/F0 prefixes and shift state, maps codes to ASCII,
// and buffers key events in a show-ahead FIFO.
module ps2_key_decoder #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       rd_en,
    input  logic       ovf_clr,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [7:0] evt_ascii,
    output logic       shift_held,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CntMax = CW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] ascii;
    } evt_t;

    function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic ext,
                                            input logic shift);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
            8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
            8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
            8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
            8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
            8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
            default: a = 8'h00;
        endcase
        if (a != 8'h00) begin
            if (shift) a = a - 8'h20;
        end else begin
            case (code)
                8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
                8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
                8'h3E: a = 8'h38;  8'h46: a = 8'h39;
                8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
                default: a = 8'h00;
            endcase
        end
        return ext ? 8'h00 : a;
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lshift_q, lshift_d, rshift_q, rshift_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    evt_t          mem_q [DEPTH];
    evt_t          mem_d [DEPTH];
    logic          ovf_q, ovf_d;

    logic is_ext, is_brk, push, pop, push_ok, empty, full;
    evt_t new_evt, head;

    assign is_ext = (state_q == StExt) || (state_q == StExtBrk);
    assign is_brk = (state_q == StBrk) || (state_q == StExtBrk);
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        push     = 1'b0;
        new_evt  = '{code: rx_byte, ext: is_ext, brk: is_brk,
                     ascii: ascii_of(rx_byte, is_ext, lshift_q | rshift_q)};
        if (rx_valid) begin
            cnt_d = '0;
            case (rx_byte)
                8'hE0:        state_d = is_brk ? StExtBrk : StExt;
                8'hF0:        state_d = is_ext ? StExtBrk : StBrk;
                8'h00, 8'hFF: state_d = StIdle;
                default: begin
                    push    = 1'b1;
                    state_d = StIdle;
                    // Shift state follows the key even if the event itself is dropped.
                    if (!is_ext && rx_byte == 8'h12) lshift_d = !is_brk;
                    if (!is_ext && rx_byte == 8'h59) rshift_d = !is_brk;
                end
            endcase
        end else if (state_q != StIdle && cnt_q == CntMax) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        pop      = rd_en && !empty;
        push_ok  = push && (!full || pop);
        mem_d    = mem_q;
        if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = new_evt;
        wr_ptr_d = wr_ptr_q + (AW + 1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
        ovf_d    = ovf_q;
        if (push && !push_ok) ovf_d = 1'b1;
        else if (ovf_clr)     ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign evt_valid  = !empty;
    assign evt_code   = empty ? 8'h00 : head.code;
    assign evt_ext    = !empty && head.ext;
    assign evt_break  = !empty && head.brk;
    assign evt_ascii  = empty ? 8'h00 : head.ascii;
    assign shift_held = lshift_q | rshift_q;
    assign overflow   = ovf_q;

endmodule
